// File: rtl/alien_calc_pkg.sv
// Shared constants, op codes and state encoding for the Alien Calculator core.
// Operands are 5-bit sign-magnitude: bit 4 = 1 means positive.
package alien_calc_pkg;

    localparam int MAG_W = 4;
    localparam int RES_W = 8;
    localparam int SM_W  = MAG_W + 1;

    localparam logic [SM_W-1:0] POS_ZERO = 5'b1_0000;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    // Two extra bits give room for the sign and for a sum of two operands.
    function automatic logic [MAG_W+1:0] sm_to_tc(input logic [SM_W-1:0] sm);
        logic [MAG_W+1:0] mag;
        mag = {2'b00, sm[MAG_W-1:0]};
        return sm[MAG_W] ? mag : -mag;
    endfunction

endpackage

// File: rtl/alien_calc_if.sv
// Switch inputs and display-facing outputs of the calculator core.
// The core takes the slave view; the stimulus side takes the master view.
interface alien_calc_if;
    import alien_calc_pkg::*;

    logic             i_go;
    logic [1:0]       i_op;
    logic [SM_W-1:0]  i_A_sw;
    logic [SM_W-1:0]  i_B_sw;
    logic [SM_W-1:0]  o_A;
    logic [SM_W-1:0]  o_B;
    logic [RES_W-1:0] o_Result;
    logic             o_Neg;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    modport master (
        output i_go, i_op, i_A_sw, i_B_sw,
        input  o_A, o_B, o_Result, o_Neg, o_busy, o_done, o_err
    );

    modport slave (
        input  i_go, i_op, i_A_sw, i_B_sw,
        output o_A, o_B, o_Result, o_Neg, o_busy, o_done, o_err
    );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned magnitude engine: shift-add multiply (LSB first) or
// restoring divide (MSB first), one step per clock, done pulses after ITER steps.
module seq_muldiv
    import alien_calc_pkg::*;
#(
    parameter int ITER = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [MAG_W-1:0] a,
    input  logic [MAG_W-1:0] b,
    output logic             done,
    output logic [RES_W-1:0] result
);

    localparam int CNT_W = $clog2(ITER + 1);

    logic             mode_q;
    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] mcand;
    logic [MAG_W-1:0] work;
    logic [MAG_W-1:0] divisor;
    logic [MAG_W-1:0] rem;
    logic [MAG_W:0]   shifted;
    logic             fits;
    logic [MAG_W-1:0] rem_trial;

    // work holds the multiplier (shifting right) or the dividend/quotient (shifting left).
    always_comb begin
        shifted   = {rem, work[MAG_W-1]};
        fits      = (shifted >= {1'b0, divisor});
        rem_trial = shifted[MAG_W-1:0] - divisor;
        result    = mode_q ? {{(RES_W-MAG_W){1'b0}}, work} : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            work    <= '0;
            divisor <= '0;
            rem     <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mode_q  <= mode;
                running <= 1'b1;
                cnt     <= CNT_W'(ITER);
                acc     <= '0;
                mcand   <= {{(RES_W-MAG_W){1'b0}}, a};
                work    <= mode ? a : b;
                divisor <= b;
                rem     <= '0;
            end else if (running) begin
                if (mode_q) begin
                    rem  <= fits ? rem_trial : shifted[MAG_W-1:0];
                    work <= {work[MAG_W-2:0], fits};
                end else begin
                    if (work[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    work  <= work >> 1;
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alien_calc_core.sv
// Alien Calculator arithmetic core: latches switch operands on a go edge,
// runs add/sub/mul/div and holds sign-magnitude results for the display.
module alien_calc_core
    import alien_calc_pkg::*;
#(
    parameter int ITER = 4
) (
    input  logic         sys_clk,
    input  logic         i_rst,
    alien_calc_if.slave  bus
);

    state_e           state;
    state_e           state_next;
    op_e              op_q;
    logic             go_q;
    logic             start;
    logic             eng_start;
    logic             eng_done;
    logic [RES_W-1:0] eng_result;
    logic             commit;
    logic [RES_W-1:0] res_next;
    logic             neg_next;
    logic             err_next;
    logic [MAG_W+1:0] sum;
    logic [MAG_W+1:0] sum_mag;
    logic             div_zero;
    logic             eng_neg;

    assign start = bus.i_go & ~go_q & (state == S_IDLE);

    seq_muldiv #(.ITER(ITER)) u_muldiv (
        .clk    (sys_clk),
        .rst    (i_rst),
        .start  (eng_start),
        .mode   (op_e'(bus.i_op) == OP_DIV),
        .a      (bus.i_A_sw[MAG_W-1:0]),
        .b      (bus.i_B_sw[MAG_W-1:0]),
        .done   (eng_done),
        .result (eng_result)
    );

    // A zero sum or product comes out with a clear sign, so "-0" never reaches the display.
    always_comb begin
        sum      = (op_q == OP_SUB) ? sm_to_tc(bus.o_A) - sm_to_tc(bus.o_B)
                                    : sm_to_tc(bus.o_A) + sm_to_tc(bus.o_B);
        sum_mag  = sum[MAG_W+1] ? -sum : sum;
        div_zero = (bus.o_B[MAG_W-1:0] == '0);
        eng_neg  = (bus.o_A[MAG_W] ^ bus.o_B[MAG_W]) & (eng_result != '0);
    end

    always_comb begin
        state_next = state;
        eng_start  = 1'b0;
        commit     = 1'b0;
        res_next   = '0;
        neg_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CALC;
                    eng_start  = (op_e'(bus.i_op) == OP_MUL) ||
                                 ((op_e'(bus.i_op) == OP_DIV) && (bus.i_B_sw[MAG_W-1:0] != '0));
                end
            end
            S_CALC: begin
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    commit     = 1'b1;
                    res_next   = {{(RES_W-MAG_W-2){1'b0}}, sum_mag};
                    neg_next   = sum[MAG_W+1];
                    state_next = S_DONE;
                end else if ((op_q == OP_DIV) && div_zero) begin
                    commit     = 1'b1;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (eng_done) begin
                    commit     = 1'b1;
                    res_next   = eng_result;
                    neg_next   = eng_neg;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // go_q resets high so a go held through reset is not seen as a fresh edge.
    always_ff @(posedge sys_clk) begin
        if (i_rst) begin
            go_q         <= 1'b1;
            op_q         <= OP_ADD;
            bus.o_A      <= POS_ZERO;
            bus.o_B      <= POS_ZERO;
            bus.o_Result <= '0;
            bus.o_Neg    <= 1'b0;
            bus.o_busy   <= 1'b0;
            bus.o_done   <= 1'b0;
            bus.o_err    <= 1'b0;
        end else begin
            go_q       <= bus.i_go;
            bus.o_done <= commit;
            if (start) begin
                bus.o_A    <= bus.i_A_sw;
                bus.o_B    <= bus.i_B_sw;
                op_q       <= op_e'(bus.i_op);
                bus.o_busy <= 1'b1;
                bus.o_err  <= 1'b0;
            end
            if (commit) begin
                bus.o_Result <= res_next;
                bus.o_Neg    <= neg_next;
                bus.o_err    <= err_next;
                bus.o_busy   <= 1'b0;
            end
        end
    end

endmodule
